conv3x3_mac: RTL and testbench

CONV3X3_MAC -- requirements
Module: conv3x3_mac

---
 rtl/conv3x3_mac.sv | 166 ++++++++++++++++
 tb/tb_conv3x3_mac.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_mac.sv
// 3x3 signed convolution MAC: nine runtime-loaded weights, three-stage
// multiply / row-sum / total pipeline, and frame coordinate tracking.
module conv3x3_mac #(
  parameter int DATA_W = 9,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ACC_W  = 2*DATA_W+4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   win0,
  input  logic signed [DATA_W-1:0]   win1,
  input  logic signed [DATA_W-1:0]   win2,
  input  logic signed [DATA_W-1:0]   win3,
  input  logic signed [DATA_W-1:0]   win4,
  input  logic signed [DATA_W-1:0]   win5,
  input  logic signed [DATA_W-1:0]   win6,
  input  logic signed [DATA_W-1:0]   win7,
  input  logic signed [DATA_W-1:0]   win8,
  input  logic                       wgt_load,
  input  logic signed [DATA_W-1:0]   wgt_in,
  output logic                       ready,
  output logic                       out_valid,
  output logic signed [ACC_W-1:0]    out_data,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       frame_done
);

  localparam int ROW_W  = $clog2(IMG_H);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int PROD_W = 2*DATA_W;
  localparam int RSUM_W = PROD_W+2;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic signed [DATA_W-1:0]  w_q [9];
  logic signed [DATA_W-1:0]  w_d [9];
  logic [ROW_W-1:0]          row_q, row_d;
  logic [COL_W-1:0]          col_q, col_d;

  logic signed [DATA_W-1:0]  win [9];
  logic signed [PROD_W-1:0]  prod_d [9];
  logic signed [PROD_W-1:0]  prod_q [9];
  logic signed [RSUM_W-1:0]  rsum_d [3];
  logic signed [RSUM_W-1:0]  rsum_q [3];
  logic signed [ACC_W-1:0]   total;

  logic                      accept, produce, last_pix;
  logic                      v1_q, v2_q;
  logic [ROW_W-1:0]          row1_q, row2_q;
  logic [COL_W-1:0]          col1_q, col2_q;
  logic                      last1_q, last2_q;

  assign win = '{win0, win1, win2, win3, win4, win5, win6, win7, win8};

  // Weight-load FSM; a load strobe always takes priority over window traffic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    case (state_q)
      IDLE, RUN: begin
        if (wgt_load) begin
          w_d[0]  = wgt_in;
          cnt_d   = 4'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (wgt_load) begin
          w_d[cnt_q] = wgt_in;
          if (cnt_q == 4'd8) begin
            cnt_d   = 4'd0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready    = (state_q == RUN);
  assign accept   = in_valid && (state_q == RUN) && !wgt_load;
  assign produce  = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign last_pix = (row_q == ROW_W'(IMG_H-1)) && (col_q == COL_W'(IMG_W-1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      if (col_q == COL_W'(IMG_W-1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_H-1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 9; k++) prod_d[k] = PROD_W'(win[k]) * PROD_W'(w_q[k]);
    for (int r = 0; r < 3; r++)
      rsum_d[r] = RSUM_W'(prod_q[3*r]) + RSUM_W'(prod_q[3*r+1]) + RSUM_W'(prod_q[3*r+2]);
    total = ACC_W'(rsum_q[0]) + ACC_W'(rsum_q[1]) + ACC_W'(rsum_q[2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q    <= IDLE;
      cnt_q      <= '0;
      for (int k = 0; k < 9; k++) w_q[k] <= '0;
      row_q      <= '0;
      col_q      <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      w_q        <= w_d;
      row_q      <= row_d;
      col_q      <= col_d;
      v1_q       <= produce;
      v2_q       <= v1_q;
      out_valid  <= v2_q;
      frame_done <= v2_q && last2_q;
      if (v2_q) begin
        out_data <= total;
        out_row  <= row2_q;
        out_col  <= col2_q;
      end
    end
  end

  // NOTE: datapath stages carry no reset; the valid bits above decide whether their contents matter.
  always_ff @(posedge clk) begin
    if (produce) begin
      prod_q  <= prod_d;
      row1_q  <= row_q;
      col1_q  <= col_q;
      last1_q <= last_pix;
    end
    if (v1_q) begin
      rsum_q  <= rsum_d;
      row2_q  <= row1_q;
      col2_q  <= col1_q;
      last2_q <= last1_q;
    end
  end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Self-checking bench for conv3x3_mac: directed load/frame/reset scenarios plus
// randomized windows, scored against a plain-arithmetic convolution model.
module tb_conv3x3_mac;

  localparam int DATA_W = 9;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
  localparam int ACC_W  = 2*DATA_W+4;

  logic                      clk = 1'b0;
  logic                      rst, in_valid, wgt_load;
  logic signed [DATA_W-1:0]  win [9];
  logic signed [DATA_W-1:0]  wgt_in;
  logic                      ready, out_valid, frame_done;
  logic signed [ACC_W-1:0]   out_data;
  logic [4:0]                out_row, out_col;

  always #5 clk = ~clk;

  conv3x3_mac #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .win0(win[0]), .win1(win[1]), .win2(win[2]), .win3(win[3]), .win4(win[4]),
    .win5(win[5]), .win6(win[6]), .win7(win[7]), .win8(win[8]),
    .wgt_load(wgt_load), .wgt_in(wgt_in), .ready(ready), .out_valid(out_valid),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  typedef struct {int due; int data; int row; int col; bit fd;} exp_t;

  exp_t exp_q[$];
  int   mw [9];
  bit   m_run;
  int   m_nload, m_row, m_col;
  int   last_data, last_row, last_col;
  int   cyc, n_cmp, n_fail, n_pulse, n_fd;
  int   wl [9];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour for one rising edge, from the inputs currently driven.
  task automatic model_edge();
    if (rst) begin
      exp_q.delete();
      for (int k = 0; k < 9; k++) mw[k] = 0;
      m_run = 0; m_nload = 0; m_row = 0; m_col = 0;
      last_data = 0; last_row = 0; last_col = 0;
    end else if (wgt_load) begin
      if (m_nload > 0) begin
        mw[m_nload] = int'(wgt_in);
        m_nload++;
        if (m_nload == 9) begin m_nload = 0; m_run = 1; end
      end else begin
        mw[0] = int'(wgt_in); m_nload = 1; m_run = 0;
      end
    end else if (m_nload > 0) begin
      m_nload = 0; m_run = 0;
    end else if (in_valid && m_run) begin
      if (m_row >= 2 && m_col >= 2) begin
        int s;
        s = 0;
        for (int k = 0; k < 9; k++) s += int'(win[k]) * mw[k];
        exp_q.push_back('{cyc + 3, s, m_row, m_col, (m_row == IMG_H-1) && (m_col == IMG_W-1)});
      end
      m_col++;
      if (m_col == IMG_W) begin
        m_col = 0; m_row++;
        if (m_row == IMG_H) m_row = 0;
      end
    end
  endtask

  task automatic check_outs();
    exp_t e;
    chk("ready", 64'(ready), 64'(m_run));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("out_valid", 64'(out_valid), 64'(1));
      chk("out_data", 64'(out_data), 64'(ACC_W'(e.data)));
      chk("out_row", 64'(out_row), 64'(e.row));
      chk("out_col", 64'(out_col), 64'(e.col));
      chk("frame_done", 64'(frame_done), 64'(e.fd));
      last_data = e.data; last_row = e.row; last_col = e.col;
    end else begin
      chk("out_valid_idle", 64'(out_valid), 64'(0));
      chk("frame_done_idle", 64'(frame_done), 64'(0));
      chk("out_data_hold", 64'(out_data), 64'(ACC_W'(last_data)));
      chk("out_row_hold", 64'(out_row), 64'(last_row));
      chk("out_col_hold", 64'(out_col), 64'(last_col));
    end
    if (out_valid === 1'b1) n_pulse++;
    if (frame_done === 1'b1) n_fd++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outs();
  endtask

  task automatic load(input int w [9]);
    for (int k = 0; k < 9; k++) begin
      wgt_load = 1'b1;
      wgt_in   = DATA_W'(w[k]);
      step();
    end
    wgt_load = 1'b0;
  endtask

  task automatic win_all(input int v);
    for (int k = 0; k < 9; k++) win[k] = DATA_W'(v);
  endtask

  task automatic win_rand();
    for (int k = 0; k < 9; k++) win[k] = DATA_W'(int'($urandom_range(0, 511)) - 256);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; wgt_load = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_fail = 0; n_pulse = 0; n_fd = 0;
    rst = 1'b1; in_valid = 1'b0; wgt_load = 1'b0; wgt_in = '0;
    win_all(0);
    step();
    step();
    chk("reset_out_data", 64'(out_data), 64'(0));
    rst = 1'b0;
    step();

    // All-ones weights, taps of 2: first producing window at (2,2) gives 18.
    for (int k = 0; k < 9; k++) wl[k] = 1;
    load(wl);
    chk("ready_after_load", 64'(ready), 64'(1));
    in_valid = 1'b1; win_all(2);
    repeat (67) step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("ones_x_two", 64'(out_data), 64'(ACC_W'(18)));

    // Signed weights: w4=-1 against -256, then the extreme product sum.
    do_reset();
    for (int k = 0; k < 9; k++) wl[k] = 0;
    wl[4] = -1;
    load(wl);
    in_valid = 1'b1; win_all(0); win[4] = -9'sd256;
    repeat (67) step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("neg_identity", 64'(out_data), 64'(ACC_W'(256)));
    for (int k = 0; k < 9; k++) wl[k] = -256;
    load(wl);
    in_valid = 1'b1; win_all(-256);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("max_sum", 64'(out_data), 64'(ACC_W'(589824)));

    // Reset one cycle after an accepted window drops it.
    in_valid = 1'b1; win_rand();
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_flush_data", 64'(out_data), 64'(0));
    repeat (4) step();
    in_valid = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    repeat (4) step();

    // Abandoned load after five words leaves the block idle.
    for (int k = 0; k < 5; k++) begin
      wgt_load = 1'b1; wgt_in = DATA_W'(k + 3);
      step();
    end
    wgt_load = 1'b0;
    step();
    chk("aborted_ready", 64'(ready), 64'(0));
    in_valid = 1'b1; win_all(5);
    repeat (5) step();
    in_valid = 1'b0;
    repeat (4) step();

    // Random weights and windows, then a reload colliding with in_valid.
    for (int k = 0; k < 9; k++) wl[k] = int'($urandom_range(0, 511)) - 256;
    load(wl);
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      win_rand();
      step();
    end
    in_valid = 1'b1; win_rand();
    wgt_load = 1'b1; wgt_in = DATA_W'(int'($urandom_range(0, 511)) - 256);
    step();
    chk("collide_row", 64'(dut.row_q), 64'(m_row));
    chk("collide_col", 64'(dut.col_q), 64'(m_col));
    chk("collide_ready", 64'(ready), 64'(0));
    for (int k = 1; k < 9; k++) begin
      wgt_in = DATA_W'(int'($urandom_range(0, 511)) - 256);
      win_rand();
      step();
    end
    wgt_load = 1'b0;
    for (int i = 0; i < 200; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      win_rand();
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Full frame, identity weight, ramp taps.
    do_reset();
    for (int k = 0; k < 9; k++) wl[k] = 0;
    wl[4] = 1;
    load(wl);
    n_pulse = 0; n_fd = 0;
    for (int idx = 0; idx < IMG_W*IMG_H; idx++) begin
      in_valid = 1'b1;
      for (int k = 0; k < 9; k++) win[k] = DATA_W'(((idx + k) % 256) - 128);
      step();
    end
    in_valid = 1'b0;
    repeat (5) step();
    chk("frame_pulses", 64'(n_pulse), 64'(900));
    chk("frame_done_count", 64'(n_fd), 64'(1));
    chk("frame_end_row", 64'(dut.row_q), 64'(0));
    chk("frame_end_col", 64'(dut.col_q), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
